// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state type and instruction-field helpers for the multi-cycle core.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ANDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BCS  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } cpu_state_t;

    function automatic int unsigned imm_width(input int unsigned data_w, input int unsigned rw);
        return data_w - OPC_W - 2 * rw;
    endfunction

    function automatic int unsigned rd_lsb(input int unsigned data_w, input int unsigned rw);
        return data_w - OPC_W - rw;
    endfunction

    function automatic int unsigned ra_lsb(input int unsigned data_w, input int unsigned rw);
        return data_w - OPC_W - 2 * rw;
    endfunction

    // Opcodes 0..5 are the register-writing ALU group that also updates ZF/CF.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_ANDI);
    endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Instruction and data memory req/ack buses of the multi-cycle core.
interface multicycle_cpu_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned PC_W   = 10
) ();

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ack;

    logic              dmem_req;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/reg_file.sv
// 2**RW x DATA_W register file: two asynchronous read ports, one synchronous write port.
module reg_file #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned RW     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int unsigned NREG = 2 ** RW;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing, ALU, flags and PC logic
// around an external req/ack instruction and data memory.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned PC_W   = 10,
    parameter int unsigned RW     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_cpu_if.master       bus,
    output logic                   halted,
    output logic [PC_W-1:0]        dbg_pc,
    output logic [3:0]             dbg_opcode
);

    localparam int unsigned IMW    = imm_width(DATA_W, RW);
    localparam int unsigned RD_LSB = rd_lsb(DATA_W, RW);
    localparam int unsigned RA_LSB = ra_lsb(DATA_W, RW);

    cpu_state_t state, state_n;

    logic [PC_W-1:0]   pc, pc_next, pc_inc, pc_br;
    logic [DATA_W-1:0] ir, op_a, op_b, res;
    logic              zf, cf;

    logic [3:0]        opcode;
    logic [RW-1:0]     rd_sel, ra_sel, rb_sel, rf_b_sel;
    logic [IMW-1:0]    imm;
    logic [DATA_W-1:0] imm_z;
    logic [DATA_W-1:0] rf_a, rf_b;

    logic [DATA_W-1:0] alu_res, add_rhs;
    logic [DATA_W:0]   add_sum;
    logic              alu_cf, alu_flag_we;

    logic fetch_req, ir_we, opnd_we, exec_en, mem_req, ld_done, rf_we;

    assign opcode   = ir[DATA_W-1 -: 4];
    assign rd_sel   = ir[RD_LSB +: RW];
    assign ra_sel   = ir[RA_LSB +: RW];
    assign imm      = ir[IMW-1:0];
    assign rb_sel   = imm[IMW-1 -: RW];
    assign imm_z    = {{(DATA_W-IMW){1'b0}}, imm};
    // Stores need R[rd] rather than R[rb], so port B is steered to rd for ST.
    assign rf_b_sel = (opcode == OP_ST) ? rd_sel : rb_sel;

    reg_file #(
        .DATA_W (DATA_W),
        .RW     (RW)
    ) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .ra_addr (ra_sel),
        .ra_data (rf_a),
        .rb_addr (rf_b_sel),
        .rb_data (rf_b),
        .we      (rf_we),
        .waddr   (rd_sel),
        .wdata   (res)
    );

    always_comb begin
        add_rhs     = (opcode == OP_ADDI) ? imm_z : op_b;
        add_sum     = {1'b0, op_a} + {1'b0, add_rhs};
        alu_res     = '0;
        alu_cf      = 1'b0;
        alu_flag_we = is_alu_op(opcode);
        case (opcode)
            OP_ADD, OP_ADDI: begin
                alu_res = add_sum[DATA_W-1:0];
                alu_cf  = add_sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_cf  = (op_a < op_b);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ANDI: alu_res = op_a & imm_z;
            default: ;
        endcase
    end

    assign pc_inc = pc + PC_W'(1);
    assign pc_br  = pc_inc + PC_W'($signed(imm));

    always_comb begin
        pc_next = pc_inc;
        case (opcode)
            OP_BEQ:  pc_next = zf ? pc_br : pc_inc;
            OP_BCS:  pc_next = cf ? pc_br : pc_inc;
            OP_JMP:  pc_next = ir[PC_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        fetch_req = 1'b0;
        ir_we     = 1'b0;
        opnd_we   = 1'b0;
        exec_en   = 1'b0;
        mem_req   = 1'b0;
        ld_done   = 1'b0;
        rf_we     = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                opnd_we = 1'b1;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (is_alu_op(opcode)) begin
                    state_n = S_WB;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    state_n = S_MEM;
                end else if (opcode == OP_HALT) begin
                    state_n = S_HALT;
                end else begin
                    state_n = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (bus.dmem_ack) begin
                    if (opcode == OP_LD) begin
                        ld_done = 1'b1;
                        state_n = S_WB;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT: ;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc   <= '0;
            ir   <= '0;
            zf   <= 1'b0;
            cf   <= 1'b0;
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
        end else begin
            if (ir_we) begin
                ir <= bus.imem_rdata;
            end
            if (opnd_we) begin
                op_a <= rf_a;
                op_b <= rf_b;
            end
            if (exec_en) begin
                pc  <= pc_next;
                res <= alu_res;
                if (alu_flag_we) begin
                    zf <= (alu_res == '0);
                    cf <= alu_cf;
                end
            end
            if (ld_done) begin
                res <= bus.dmem_rdata;
            end
        end
    end

    // State resets to FETCH, so the fetch request is masked while reset is held.
    assign bus.imem_req   = fetch_req & reset_n;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = mem_req;
    assign bus.dmem_we    = mem_req & (opcode == OP_ST);
    assign bus.dmem_addr  = PC_W'(op_a + imm_z);
    assign bus.dmem_wdata = op_b;

    assign halted     = (state == S_HALT);
    assign dbg_pc     = pc;
    assign dbg_opcode = opcode;

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle 18-bit core. It executes one instruction per FETCH→DECODE→EXEC→(MEM)→(WB) pass under an explicit FSM, and talks to external instruction and data memories through req/ack handshakes. It adds registered ZF/CF flags, taken branches, jumps and HALT. It sits between the top-level testbench/SoC wrapper and the memory models, and replaces the core's internal PC/control glue.

## Interface
- DATA_W, 18, datapath and instruction width
- PC_W, 10, program-counter and data-address width (requires PC_W ≤ DATA_W−8)
- RW, 4, register-select width; register count = 2**RW (requires DATA_W ≥ 4+3·RW)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset (only one clock domain)
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  PC_W  (ra + zext(imm))[PC_W−1:0]
- dmem_wdata  out  DATA_W  store data (= R[rd])
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- halted  out  1  core is in HALT
- dbg_pc  out  PC_W  current PC
- dbg_opcode  out  4  opcode of the latched IR

## Operation
- IR fields: opcode = IR[DATA_W−1 -: 4], rd = next RW bits, ra = next RW bits, imm = remaining IMW = DATA_W−4−2·RW low bits, rb = top RW bits of imm.
- Opcodes: 0 ADD rd=ra+rb; 1 SUB rd=ra−rb; 2 AND; 3 OR; 4 ADDI rd=ra+zext(imm); 5 ANDI; 6 LD rd=M[ra+zext(imm)]; 7 ST M[ra+zext(imm)]=rd; 8 BEQ (taken if ZF); 9 BCS (taken if CF); A JMP PC=IR[PC_W−1:0]; F HALT; B–E NOP.
- Taken branch: PC ← PC+1+sext(imm), computed mod 2**PC_W. Not taken and all other non-jump opcodes: PC ← PC+1, with wrap 2**PC_W−1 → 0.
- Flags update only in EXEC of ADD/SUB/AND/OR/ADDI/ANDI. ZF = (result==0). CF = carry-out for ADD/ADDI, borrow (ra<rb unsigned) for SUB, 0 for logic ops. Branches read the flags as they were before the branch.
- Arithmetic is DATA_W-bit modulo.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1, held with stable imem_addr until imem_ack; on ack, latch IR and go to DECODE.
  - DECODE: read ra/rb/rd into operand registers, then go to EXEC.
  - EXEC: compute ALU result, flags and next PC. ALU ops go to WB; LD/ST go to MEM; branch/JMP/NOP go to FETCH; HALT goes to HALT.
  - MEM: dmem_req=1 with stable addr/we/wdata until dmem_ack. LD latches rdata and goes to WB; ST goes to FETCH.
  - WB: write rd, then go to FETCH.
  - HALT: absorbing; halted=1, no requests. Only reset_n leaves it.
- A same-cycle ack (combinational memory) is legal. req drops the cycle after ack.

## Timing
- Reset (reset_n low, asynchronous): PC=0, IR=0, ZF=CF=0, all registers 0, state=FETCH. While reset is low all outputs are 0, including imem_req.
- The first imem_req occurs in the first clk cycle after reset_n rises.
- Latency with zero-wait memory: ALU op 4 cycles; LD 5; ST 4; branch/JMP/NOP 3; HALT reached 3 cycles after its fetch.
- Each wait cycle (ack low) adds one cycle in FETCH or MEM.
- Reset mid-handshake abandons the transfer immediately; a late ack after reset is ignored.
- The register-file write and the PC update in the same cycle never conflict, since they occur in different states.

## Structure
- Package cpu_pkg: opcode localparams, state enum, field-offset functions derived from DATA_W/RW.
- Sub-module reg_file: 2**RW × DATA_W registers, two async read ports, one sync write port, async active-low clear.
- FSM, ALU and PC logic live in multicycle_cpu.

## Test plan
- Reset release: imem_req=1 and imem_addr=0 in the first cycle; hold imem_ack low for 3 cycles → req and addr stay stable, no IR change.
- ADDI r1=r0+63; ADD r2=r1+r1 → R2=126, ZF=0, CF=0; SUB r3=r0−r1 → R3=2**18−63, CF=1.
- ST r2 → M[5]; LD r4 ← M[5] with 2-cycle dmem_ack delay → R4=126, dmem_we=1 only during ST, LD takes 7 cycles.
- SUB r5=r1−r1 (ZF=1); BEQ imm=−2 (6'h3E) at PC=9 → next fetch at PC=8. BCS with CF=0 → PC+1.
- JMP to 10'h3FF then NOP → next fetch at PC 0 (wrap); HALT → halted=1 and no further req; reset_n pulse mid-FETCH → PC=0, halted=0.
